rob_commit: RTL

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit.sv | 104 ++++++++++
 1 files changed

// File: rtl/rob_commit.sv
// rob_commit: retires ROB head slots each cycle, drives registered RF writes and a store-buffer handshake.
// Optional macro COMMIT_STATS_EN enables the stat_retired/stat_killed counters.
module rob_commit #(
  parameter int EXT_COUNT    = 4,
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [EXT_COUNT-1:0]    head_valid,
  input  logic [EXT_COUNT-1:0]    head_kill,
  input  logic [4:0]              head_dest_reg [EXT_COUNT],
  input  logic [EXT_COUNT-1:0]    head_dest_valid,
  input  logic [31:0]             head_result [EXT_COUNT],
  input  logic [EXT_COUNT-1:0]    head_is_store,
  input  logic [31:0]             head_st_addr [EXT_COUNT],
  input  logic [31:0]             head_st_data [EXT_COUNT],
  input  logic                    rob_empty,
  output logic                    consume,
  output logic [EXTCOUNTLOG2-1:0] consume_count,
  output logic [EXT_COUNT-1:0]    rf_we,
  output logic [4:0]              rf_waddr [EXT_COUNT],
  output logic [31:0]             rf_wdata [EXT_COUNT],
  output logic                    st_req,
  output logic [31:0]             st_addr,
  output logic [31:0]             st_data,
  input  logic                    st_ack,
  output logic [31:0]             stat_retired,
  output logic [31:0]             stat_killed
);
  typedef enum logic {RUN, ST_WAIT} state_t;
  state_t state, state_nx;
  logic [EXT_COUNT-1:0] grp, ret, wr, we_nx;
  logic [EXTCOUNTLOG2:0] n, n_m1;
  logic stop, st_start, unused_bits;
  always_comb begin
    grp = '0;
    n = '0;
    stop = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      stop = stop | ~head_valid[i] | (head_is_store[i] & ~head_kill[i]);
      grp[i] = ~stop;
      n = n + {{EXTCOUNTLOG2{1'b0}}, ~stop};
    end
    n_m1 = n - {{EXTCOUNTLOG2{1'b0}}, 1'b1};
    st_start = (state == RUN) & ~rob_empty & head_valid[0] & head_is_store[0] & ~head_kill[0];
    consume = ~rob_empty & ((state == RUN) ? |grp : st_ack);
    consume_count = (state == RUN) ? n_m1[EXTCOUNTLOG2-1:0] : '0;
    ret = ~consume ? '0 : (state == RUN) ? grp : {{(EXT_COUNT-1){1'b0}}, 1'b1};
    state_nx = rob_empty ? state : (state == RUN) ? (st_start ? ST_WAIT : RUN) : (st_ack ? RUN : ST_WAIT);
    for (int i = 0; i < EXT_COUNT; i++)
      wr[i] = ret[i] & ~head_kill[i] & head_dest_valid[i] & (head_dest_reg[i] != 5'd0);
    // a later slot writing the same register overrides earlier ones in the group
    for (int i = 0; i < EXT_COUNT; i++) begin
      we_nx[i] = wr[i];
      for (int j = i + 1; j < EXT_COUNT; j++)
        if (wr[j] && head_dest_reg[j] == head_dest_reg[i]) we_nx[i] = 1'b0;
    end
    unused_bits = n_m1[EXTCOUNTLOG2];
    for (int i = 1; i < EXT_COUNT; i++)
      unused_bits = unused_bits ^ (^head_st_addr[i]) ^ (^head_st_data[i]);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_nx;
  assign st_req = (state == ST_WAIT);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st_addr <= '0;
      st_data <= '0;
      rf_we <= '0;
      rf_waddr <= '{default: '0};
      rf_wdata <= '{default: '0};
    end else begin
      rf_we <= we_nx;
      rf_waddr <= head_dest_reg;
      rf_wdata <= head_result;
      if (st_start) begin
        st_addr <= head_st_addr[0];
        st_data <= head_st_data[0];
      end
    end
`ifdef COMMIT_STATS_EN
  logic [31:0] add_r, add_k;
  always_comb begin
    add_r = '0;
    add_k = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      add_r = add_r + {31'd0, ret[i] & ~head_kill[i]};
      add_k = add_k + {31'd0, ret[i] & head_kill[i]};
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stat_retired <= '0;
      stat_killed <= '0;
    end else begin
      stat_retired <= stat_retired + add_r;
      stat_killed <= stat_killed + add_k;
    end
`else
  assign stat_retired = '0;
  assign stat_killed = '0;
`endif
endmodule
